// File: rtl/window_gen_3x3.sv
// Streaming 3x3 RGB neighbourhood generator for raster-order video.
// Two line buffers per channel feed a three-column shift window.
module window_gen_3x3 #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       in_sof,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   output logic [7:0] a_r,
   output logic [7:0] b_r,
   output logic [7:0] c_r,
   output logic [7:0] d_r,
   output logic [7:0] e_r,
   output logic [7:0] f_r,
   output logic [7:0] g_r,
   output logic [7:0] h_r,
   output logic [7:0] i_r,
   output logic [7:0] a_g,
   output logic [7:0] b_g,
   output logic [7:0] c_g,
   output logic [7:0] d_g,
   output logic [7:0] e_g,
   output logic [7:0] f_g,
   output logic [7:0] g_g,
   output logic [7:0] h_g,
   output logic [7:0] i_g,
   output logic [7:0] a_b,
   output logic [7:0] b_b,
   output logic [7:0] c_b,
   output logic [7:0] d_b,
   output logic [7:0] e_b,
   output logic [7:0] f_b,
   output logic [7:0] g_b,
   output logic [7:0] h_b,
   output logic [7:0] i_b,
   output logic       win_valid,
   output logic       win_last
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO = CW'(2);
   localparam logic [RW-1:0] ROW_TWO = RW'(2);

   logic [CW-1:0] col_q, col_d, col_cur;
   logic [RW-1:0] row_q, row_d, row_cur;
   logic          win_fire, win_end;
   logic          win_valid_q, win_last_q;
   logic [7:0]    pix   [3];
   logic [7:0]    up1   [3];
   logic [7:0]    up2   [3];
   logic [7:0]    lb1_q [3][IMG_WIDTH];
   logic [7:0]    lb2_q [3][IMG_WIDTH];
   logic [7:0]    sh_q  [3][6];
   logic [7:0]    tap_q [3][9];

   assign pix[0] = in_r;
   assign pix[1] = in_g;
   assign pix[2] = in_b;

   // in_sof forces the current pixel to (0,0) whatever the counters say
   always_comb begin
      col_cur = in_sof ? '0 : col_q;
      row_cur = in_sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (in_valid) begin
         if (col_cur == COL_MAX) begin
            col_d = '0;
            row_d = (row_cur == ROW_MAX) ? '0 : row_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
            row_d = row_cur;
         end
      end
      win_fire = in_valid && (col_cur >= COL_TWO)
                 && (row_cur >= ROW_TWO);
      win_end  = win_fire && (col_cur == COL_MAX)
                 && (row_cur == ROW_MAX);
      for (int ch = 0; ch < 3; ch++) begin
         up1[ch] = lb1_q[ch][col_cur];
         up2[ch] = lb2_q[ch][col_cur];
      end
   end

   // sh_q per channel: [0..1] top, [2..3] middle, [4..5] bottom (col-2, col-1)
   always_ff @(posedge clk) begin
      if (in_valid && !reset) begin
         for (int ch = 0; ch < 3; ch++) begin
            lb2_q[ch][col_cur] <= up1[ch];
            lb1_q[ch][col_cur] <= pix[ch];
            sh_q[ch][0]        <= sh_q[ch][1];
            sh_q[ch][1]        <= up2[ch];
            sh_q[ch][2]        <= sh_q[ch][3];
            sh_q[ch][3]        <= up1[ch];
            sh_q[ch][4]        <= sh_q[ch][5];
            sh_q[ch][5]        <= pix[ch];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 9; k++) begin
               tap_q[ch][k] <= '0;
            end
         end
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_valid_q <= win_fire;
         win_last_q  <= win_end;
         if (win_fire) begin
            for (int ch = 0; ch < 3; ch++) begin
               tap_q[ch][0] <= sh_q[ch][0];
               tap_q[ch][1] <= sh_q[ch][1];
               tap_q[ch][2] <= up2[ch];
               tap_q[ch][3] <= sh_q[ch][2];
               tap_q[ch][4] <= sh_q[ch][3];
               tap_q[ch][5] <= up1[ch];
               tap_q[ch][6] <= sh_q[ch][4];
               tap_q[ch][7] <= sh_q[ch][5];
               tap_q[ch][8] <= pix[ch];
            end
         end
      end
   end

   assign a_r = tap_q[0][0];
   assign b_r = tap_q[0][1];
   assign c_r = tap_q[0][2];
   assign d_r = tap_q[0][3];
   assign e_r = tap_q[0][4];
   assign f_r = tap_q[0][5];
   assign g_r = tap_q[0][6];
   assign h_r = tap_q[0][7];
   assign i_r = tap_q[0][8];
   assign a_g = tap_q[1][0];
   assign b_g = tap_q[1][1];
   assign c_g = tap_q[1][2];
   assign d_g = tap_q[1][3];
   assign e_g = tap_q[1][4];
   assign f_g = tap_q[1][5];
   assign g_g = tap_q[1][6];
   assign h_g = tap_q[1][7];
   assign i_g = tap_q[1][8];
   assign a_b = tap_q[2][0];
   assign b_b = tap_q[2][1];
   assign c_b = tap_q[2][2];
   assign d_b = tap_q[2][3];
   assign e_b = tap_q[2][4];
   assign f_b = tap_q[2][5];
   assign g_b = tap_q[2][6];
   assign h_b = tap_q[2][7];
   assign i_b = tap_q[2][8];

   assign win_valid = win_valid_q;
   assign win_last  = win_last_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image: a frame-image model
// predicts every window; directed frames plus random traffic.
module tb_window_gen_3x3;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_sof;
   logic [7:0] in_r, in_g, in_b;
   logic [7:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r;
   logic [7:0] a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g;
   logic [7:0] a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b;
   logic       win_valid, win_last;

   always #5 clk = ~clk;

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .a_r(a_r), .b_r(b_r), .c_r(c_r), .d_r(d_r), .e_r(e_r),
      .f_r(f_r), .g_r(g_r), .h_r(h_r), .i_r(i_r),
      .a_g(a_g), .b_g(b_g), .c_g(c_g), .d_g(d_g), .e_g(e_g),
      .f_g(f_g), .g_g(g_g), .h_g(h_g), .i_g(i_g),
      .a_b(a_b), .b_b(b_b), .c_b(c_b), .d_b(d_b), .e_b(e_b),
      .f_b(f_b), .g_b(g_b), .h_b(h_b), .i_b(i_b),
      .win_valid(win_valid), .win_last(win_last)
   );

   wire [71:0] dut_r = {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r};
   wire [71:0] dut_g = {a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g};
   wire [71:0] dut_b = {a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b};

   int   n_chk = 0, n_fail = 0;
   int   n_pulse = 0, n_last = 0;
   bit   started = 1'b0;
   logic [7:0] img [3][H][W];
   logic [7:0] et  [3][9];
   logic exp_v = 1'b0, exp_l = 1'b0;
   int   mrow = 0, mcol = 0;

   task automatic check(input string name, input logic [71:0] act,
                        input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] pack_exp(input int ch);
      logic [71:0] r = '0;
      for (int k = 0; k < 9; k++) r = {r[63:0], et[ch][k]};
      return r;
   endfunction

   // One clock: drive inputs, predict from the frame image, commit after the edge
   task automatic step(input logic rst, input logic v, input logic sof,
                       input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
      logic [7:0] nt [3][9];
      logic nv, nl;
      reset = rst; in_valid = v; in_sof = sof;
      in_r = r; in_g = g; in_b = b;
      nt = et; nv = 1'b0; nl = 1'b0;
      if (rst) begin
         mrow = 0; mcol = 0;
         for (int ch = 0; ch < 3; ch++)
            for (int k = 0; k < 9; k++) nt[ch][k] = 8'h00;
      end else if (v) begin
         if (sof) begin mrow = 0; mcol = 0; end
         img[0][mrow][mcol] = r;
         img[1][mrow][mcol] = g;
         img[2][mrow][mcol] = b;
         if (mrow >= 2 && mcol >= 2) begin
            nv = 1'b1;
            nl = (mrow == H-1) && (mcol == W-1);
            for (int ch = 0; ch < 3; ch++)
               for (int k = 0; k < 9; k++)
                  nt[ch][k] = img[ch][mrow-2+k/3][mcol-2+k%3];
         end
         mcol++;
         if (mcol == W) begin mcol = 0; mrow = (mrow + 1) % H; end
      end
      @(posedge clk);
      #1;
      et = nt; exp_v = nv; exp_l = nl;
   endtask

   task automatic pix(input logic sof, input logic [7:0] r);
      step(1'b0, 1'b1, sof, r, r + 8'h40, r + 8'h80);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic frame_ramp(input bit gaps);
      int p0 = n_pulse, l0 = n_last;
      for (int i = 0; i < 16; i++) begin
         if (gaps && i > 0) idle();
         pix(i == 0, 8'(i));
         if (i == 9) check("no_early_win", 72'(win_valid), 72'h0);
         if (i == 10) begin
            check("first_win_r", dut_r, 72'h00_01_02_04_05_06_08_09_0A);
            check("first_win_e_g", 72'(e_g), 72'h45);
            check("model_first_win", pack_exp(0),
                  72'h00_01_02_04_05_06_08_09_0A);
         end
         if (i == 15)
            check("last_win", {e_r, i_r, 7'b0, win_last}, 72'h0A_0F_01);
      end
      idle();
      check("frame_pulses", 72'(n_pulse - p0), 72'd4);
      check("frame_last", 72'(n_last - l0), 72'd1);
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("win_valid", 72'(win_valid), 72'(exp_v));
         check("win_last", 72'(win_last), 72'(exp_l));
         check("taps_r", dut_r, pack_exp(0));
         check("taps_g", dut_g, pack_exp(1));
         check("taps_b", dut_b, pack_exp(2));
         if (win_valid) n_pulse++;
         if (win_last) n_last++;
      end
   end

   initial begin
      int p0, l0;
      step(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
      started = 1'b1;
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      check("reset_taps", dut_r | dut_g | dut_b, 72'h0);
      check("reset_flags", 72'({win_valid, win_last}), 72'h0);
      idle();

      frame_ramp(1'b0);
      frame_ramp(1'b1);

      for (int i = 0; i < 6; i++) pix(i == 0, 8'(i + 100));
      for (int j = 0; j < 16; j++) begin
         pix(j == 0, 8'(j));
         if (j == 9) check("sof_no_early", 72'(win_valid), 72'h0);
         if (j == 10) begin
            check("sof_first_valid", 72'(win_valid), 72'h1);
            check("sof_first_win", dut_r, 72'h00_01_02_04_05_06_08_09_0A);
         end
      end
      idle();

      for (int i = 0; i < 10; i++) pix(i == 0, 8'(i + 50));
      step(1'b1, 1'b1, 1'b0, 8'h77, 8'h77, 8'h77);
      frame_ramp(1'b0);

      p0 = n_pulse; l0 = n_last;
      for (int i = 0; i < 16; i++)
         step(1'b0, 1'b1, i == 0, 8'hFF, 8'hFF, 8'hFF);
      for (int i = 0; i < 16; i++)
         step(1'b0, 1'b1, i == 0, 8'h00, 8'h00, 8'h00);
      idle();
      check("two_frames_pulses", 72'(n_pulse - p0), 72'd8);
      check("two_frames_last", 72'(n_last - l0), 72'd2);
      check("zero_frame_taps", dut_r | dut_g | dut_b, 72'h0);

      for (int n = 0; n < 600; n++) begin
         logic v, s, rs;
         v  = $urandom_range(0, 99) < 75;
         s  = v && ($urandom_range(0, 99) < 3);
         rs = $urandom_range(0, 299) == 0;
         step(rs, v, s, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
